// File: rtl/dtree_seq_ctrl_if.sv
// Sample/result handshake and node-table configuration bus for dtree_seq_ctrl.
interface dtree_seq_ctrl_if #(
  parameter int NFEAT = 5,
  parameter int FW    = 8,
  parameter int AW    = 6,
  parameter int DW    = 27
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NFEAT*FW-1:0]   in_x;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_class;
  logic                  out_err;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [DW-1:0]         cfg_data;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_err
  );
endinterface

// File: rtl/dtree_seq_ctrl.sv
// Decision-tree walker: one node evaluated per cycle from a register-file node table.
//   state | meaning
//   IDLE  | waiting for a sample; node table writable
//   WALK  | evaluating node[ptr], one node per cycle
//   DONE  | result held until out_ready
module dtree_seq_ctrl #(
  parameter int NFEAT   = 5,
  parameter int FW      = 8,
  parameter int NODES   = 64,
  parameter int AW      = 6,
  parameter int MAXSTEP = 16
) (
  input  logic          clk,
  input  logic          rst,
  dtree_seq_ctrl_if.slave bus,
  output logic          busy,
  output logic [15:0]   sample_cnt
);
  localparam int SW       = $clog2(MAXSTEP);
  localparam int FIW      = 3;
  localparam int SHW      = 3;
  localparam int THR_LSB  = 2 * AW;
  localparam int SH_LSB   = THR_LSB + FW;
  localparam int FI_LSB   = SH_LSB + SHW;
  localparam int LEAF_BIT = FI_LSB + FIW;
  localparam int DW       = LEAF_BIT + 1;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                    state_q, state_d;
  logic [DW-1:0]             node_mem [NODES];
  logic [NFEAT-1:0][FW-1:0]  x_q, x_d;
  logic [AW-1:0]             ptr_q, ptr_d;
  logic [SW-1:0]             step_q, step_d;
  logic                      cls_q, cls_d;
  logic                      err_q, err_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      mem_we;

  logic [DW-1:0]   node;
  logic            node_leaf;
  logic [FIW-1:0]  node_fi;
  logic [SHW-1:0]  node_sh;
  logic [FW-1:0]   node_thr;
  logic [AW-1:0]   node_l, node_r;
  logic [FW-1:0]   feat_val;
  logic            go_left;

  assign node      = node_mem[ptr_q];
  assign node_leaf = node[LEAF_BIT];
  assign node_fi   = node[FI_LSB +: FIW];
  assign node_sh   = node[SH_LSB +: SHW];
  assign node_thr  = node[THR_LSB +: FW];
  assign node_l    = node[AW +: AW];
  assign node_r    = node[0 +: AW];

  // Single shared feature mux, shifter and comparator; out-of-range index reads 0.
  always_comb begin
    feat_val = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (node_fi == FIW'(i)) feat_val = x_q[i];
    end
  end

  assign go_left = (feat_val >> node_sh) <= node_thr;

  assign mem_we = bus.cfg_we && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) node_mem[i] <= '0;
    end else if (mem_we) begin
      node_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    cls_d   = cls_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          ptr_d   = '0;
          step_d  = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        step_d = step_q + SW'(1);
        if (node_leaf) begin
          cls_d   = node[THR_LSB];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (node_fi >= FIW'(NFEAT) || step_q == SW'(MAXSTEP - 1)) begin
          cls_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d = go_left ? node_l : node_r;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      ptr_q   <= '0;
      step_q  <= '0;
      cls_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_class = cls_q;
  assign bus.out_err   = err_q;
  assign busy          = (state_q != IDLE);
  assign sample_cnt    = cnt_q;
endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Bench for dtree_seq_ctrl: tree-walk reference model checked every cycle plus literal expectations.
module tb_dtree_seq_ctrl;
  localparam int MAXSTEP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] sample_cnt;

  dtree_seq_ctrl_if bus ();

  dtree_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: node table, phase (0 idle, 1 walking, 2 result), cycles left, result, count
  logic [26:0] mtab [64];
  int          mphase = 0;
  int          mrem   = 0;
  logic        mcls   = 1'b0;
  logic        merr   = 1'b0;
  int          mcnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] nd(input int f, input int sh, input int thr, input int l, input int r);
    return {1'b0, 3'(f), 3'(sh), 8'(thr), 6'(l), 6'(r)};
  endfunction

  function automatic logic [26:0] leaf(input logic c);
    return {1'b1, 3'd0, 3'd0, 7'd0, c, 12'd0};
  endfunction

  // Follow the tree from node 0 on the model table; k = nodes visited.
  task automatic mdl_walk(input logic [39:0] x, output logic cls, output logic err, output int k);
    int          p;
    int          fi;
    logic [26:0] w;
    logic [7:0]  fv;
    p   = 0;
    cls = 1'b0;
    err = 1'b1;
    k   = MAXSTEP;
    for (int s = 1; s <= MAXSTEP; s++) begin
      w  = mtab[p];
      fi = int'(w[25:23]);
      if (w[26]) begin
        cls = w[12];
        err = 1'b0;
        k   = s;
        return;
      end
      if (fi > 4) begin
        k = s;
        return;
      end
      fv = x[fi*8 +: 8];
      p  = ((fv >> w[22:20]) <= w[19:12]) ? int'(w[11:6]) : int'(w[5:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mphase = 0;
      mrem   = 0;
      mcnt   = 0;
      for (int i = 0; i < 64; i++) mtab[i] = '0;
    end
    chk("in_ready", 32'(bus.in_ready), 32'(mphase == 0));
    chk("out_valid", 32'(bus.out_valid), 32'(mphase == 2));
    chk("busy", 32'(busy), 32'(mphase != 0));
    chk("sample_cnt", 32'(sample_cnt), 32'(mcnt));
    if (mphase == 2) begin
      chk("out_class", 32'(bus.out_class), 32'(mcls));
      chk("out_err", 32'(bus.out_err), 32'(merr));
    end
    if (!rst) begin
      case (mphase)
        0: begin
          if (bus.cfg_we) mtab[bus.cfg_addr] = bus.cfg_data;
          if (bus.in_valid) begin
            mdl_walk(bus.in_x, mcls, merr, mrem);
            mphase = 1;
          end
        end
        1: begin
          mrem--;
          if (mrem == 0) mphase = 2;
        end
        default: begin
          if (bus.out_ready) begin
            if (mcnt < 65535) mcnt++;
            mphase = 0;
          end
        end
      endcase
    end
  end

  task automatic wr_node(input int a, input logic [26:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 6'(a);
    bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  // Offer a sample (optionally with a same-cycle write), measure latency, hold DONE for
  // 'hold' cycles (optionally pulsing writes), then hand the result off.
  task automatic do_sample(input string nm, input logic [39:0] x, input int hold,
                           input bit wr_acc, input bit wr_done, input int wa, input logic [26:0] wd,
                           input logic ecls, input logic eerr, input int elat);
    int lat;
    bus.in_x     = x;
    bus.in_valid = 1'b1;
    bus.cfg_we   = wr_acc;
    bus.cfg_addr = 6'(wa);
    bus.cfg_data = wd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_class"}, 32'(bus.out_class), 32'(ecls));
    chk({nm, "_err"}, 32'(bus.out_err), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      bus.cfg_we   = wr_done && (i % 2 == 0);
      bus.cfg_addr = 6'(wa);
      bus.cfg_data = wd;
      @(posedge clk); #1;
    end
    bus.cfg_we = 1'b0;
    if (hold > 0) begin
      chk({nm, "_held_class"}, 32'(bus.out_class), 32'(ecls));
      chk({nm, "_held_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_back_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic pc;
    logic pe;
    int   pk;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_class", 32'(bus.out_class), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);

    do_sample("unconfigured", 40'h12_3456_789A, 0, 0, 0, 0, '0, 1'b0, 1'b1, 16);

    wr_node(0, nd(0, 1, 10, 1, 2));
    wr_node(1, leaf(1'b1));
    wr_node(2, leaf(1'b0));
    @(negedge clk);
    mdl_walk(40'd20, pc, pe, pk);
    chk("model_x20_class", 32'(pc), 32'd1);
    chk("model_x20_k", 32'(pk), 32'd2);
    mdl_walk(40'd22, pc, pe, pk);
    chk("model_x22_class", 32'(pc), 32'd0);
    @(posedge clk); #1;

    do_sample("x0_20", 40'd20, 0, 0, 0, 0, '0, 1'b1, 1'b0, 2);
    do_sample("x0_22", 40'd22, 0, 0, 0, 0, '0, 1'b0, 1'b0, 2);
    do_sample("x0_21", 40'hFF_FFFF_FF15, 1, 0, 0, 0, '0, 1'b1, 1'b0, 2);
    do_sample("x0_255", 40'd255, 0, 0, 0, 0, '0, 1'b0, 1'b0, 2);

    do_sample("hold_done", 40'd22, 5, 0, 1, 1, leaf(1'b0), 1'b0, 1'b0, 2);
    do_sample("after_ignored_wr", 40'd20, 0, 0, 0, 0, '0, 1'b1, 1'b0, 2);

    do_sample("wr_with_accept", 40'd22, 0, 1, 0, 0, leaf(1'b1), 1'b1, 1'b0, 1);

    wr_node(0, nd(6, 0, 0, 1, 2));
    do_sample("bad_feature", 40'd20, 0, 0, 0, 0, '0, 1'b0, 1'b1, 1);

    wr_node(0, nd(4, 3, 5, 1, 2));
    do_sample("x4_47", 40'h2F_0000_000A, 0, 0, 0, 0, '0, 1'b1, 1'b0, 2);
    do_sample("x4_48", 40'h30_FFFF_FFFF, 0, 0, 0, 0, '0, 1'b0, 1'b0, 2);

    for (int i = 0; i < 15; i++) wr_node(i, nd(0, 0, 255, i + 1, i + 1));
    wr_node(15, leaf(1'b1));
    do_sample("leaf_at_16", 40'd0, 0, 0, 0, 0, '0, 1'b1, 1'b0, 16);
    wr_node(15, nd(0, 0, 255, 16, 16));
    wr_node(16, leaf(1'b1));
    do_sample("leaf_at_17", 40'd0, 0, 0, 0, 0, '0, 1'b0, 1'b1, 16);

    wr_node(0, nd(0, 1, 10, 1, 2));
    wr_node(1, nd(0, 0, 255, 1, 1));
    wr_node(2, leaf(1'b0));
    bus.in_x     = 40'd20;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_sample_cnt", 32'(sample_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_sample("table_cleared", 40'd22, 0, 0, 0, 0, '0, 1'b0, 1'b1, 16);

    wr_node(0, leaf(1'b1));
    force dut.cnt_q = 16'd65533;
    mcnt = 65533;
    #1 release dut.cnt_q;
    do_sample("sat_a", 40'd1, 0, 0, 0, 0, '0, 1'b1, 1'b0, 1);
    chk("cnt_65534", 32'(sample_cnt), 32'd65534);
    do_sample("sat_b", 40'd2, 0, 0, 0, 0, '0, 1'b1, 1'b0, 1);
    do_sample("sat_c", 40'd3, 0, 0, 0, 0, '0, 1'b1, 1'b0, 1);
    chk("cnt_saturated", 32'(sample_cnt), 32'd65535);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
